// File: rtl/spi_master.sv
// SPI mode-0 initiator: full duplex, MSB first, 1..DATA_W bits per transfer,
// valid/ready request and response channels, sck = clock / (2*DIV).
module spi_master #(
    parameter int DATA_W = 16,
    parameter int SS_W   = 8,
    parameter int DIV    = 2
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DATA_W-1:0]         req_data,
    input  logic [$clog2(DATA_W)-1:0] req_len,
    input  logic [SS_W-1:0]           req_ss,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      sck,
    output logic [SS_W-1:0]           ss_n,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DIV_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    r_len;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_resp_valid;
    logic                r_sck;
    logic                r_mosi;
    logic [SS_W-1:0]     r_ss_n;

    logic                w_half_end;
    logic [CNT_W-1:0]    w_len_eff;
    logic [DATA_W-1:0]   w_tx_aligned;
    logic [DATA_W-1:0]   w_mask;

    assign w_half_end   = (r_div == DIV_W'(DIV - 1));
    assign w_len_eff    = (req_len == '0) ? CNT_W'(DATA_W) : CNT_W'(req_len);
    assign w_tx_aligned = req_data << (DATA_W - int'(w_len_eff));
    assign w_mask       = {DATA_W{1'b1}} >> (DATA_W - int'(r_len));

    assign req_ready  = resetn && (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign sck        = r_sck;
    assign ss_n       = r_ss_n;
    assign mosi       = r_mosi;

    // NOTE: registers update with <= so every block sees the pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // NOTE: w_next gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)  w_next = S_SETUP;
            S_SETUP: if (w_half_end) w_next = S_HIGH;
            S_HIGH:  if (w_half_end) w_next = (r_bit_cnt == r_len) ? S_HOLD : S_LOW;
            S_LOW:   if (w_half_end) w_next = S_HIGH;
            S_HOLD:  if (w_half_end) w_next = S_DONE;
            S_DONE:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_div        <= '0;
            r_bit_cnt    <= '0;
            r_len        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_resp_data  <= '0;
            r_resp_valid <= 1'b0;
            r_sck        <= 1'b0;
            r_mosi       <= 1'b1;
            r_ss_n       <= '1;
        end else begin
            // Divider runs only in the timed states and restarts on every state change.
            if (w_next != r_state || r_state == S_IDLE || r_state == S_DONE)
                r_div <= '0;
            else
                r_div <= r_div + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_len     <= w_len_eff;
                        r_tx      <= w_tx_aligned;
                        r_rx      <= '0;
                        r_bit_cnt <= '0;
                        r_ss_n    <= ~req_ss;
                        r_mosi    <= w_tx_aligned[DATA_W-1];
                    end
                end
                S_SETUP, S_LOW: begin
                    if (w_half_end) begin
                        r_sck     <= 1'b1;
                        r_rx      <= {r_rx[DATA_W-2:0], miso};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (w_half_end) begin
                        r_sck <= 1'b0;
                        if (r_bit_cnt != r_len) begin
                            r_tx   <= r_tx << 1;
                            r_mosi <= r_tx[DATA_W-2];
                        end
                    end
                end
                S_HOLD: begin
                    if (w_half_end) begin
                        r_ss_n       <= '1;
                        r_mosi       <= 1'b1;
                        r_resp_data  <= r_rx & w_mask;
                        r_resp_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_ready) r_resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master: loopback, tied-high miso,
// full-length, response backpressure, bit-reversal responder, mid-transfer reset.
module tb_spi_master;

    logic        clock;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [3:0]  req_len;
    logic [7:0]  req_ss;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        sck;
    logic [7:0]  ss_n;
    logic        mosi;
    logic        miso;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_cyc  = 0;

    // Bus monitor / responder state (written only by the monitor process).
    logic        mon_clr;
    int          miso_mode;
    int          rise_cnt;
    int          run;
    int          hi_min, hi_max, lo_min, lo_max;
    int          viol;
    logic        prev_sck, prev_mosi;
    logic [15:0] mosi_seq;
    logic [7:0]  ss_at_rise;
    logic [7:0]  rsp_sh;
    logic [7:0]  rsp_rev;

    spi_master #(.DATA_W(16), .SS_W(8), .DIV(2)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_len    (req_len),
        .req_ss     (req_ss),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .sck        (sck),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    always @(negedge clock) begin
        if (mon_clr) begin
            rise_cnt   <= 0;
            run        <= 1;
            hi_min     <= 99;
            hi_max     <= 0;
            lo_min     <= 99;
            lo_max     <= 0;
            viol       <= 0;
            mosi_seq   <= '0;
            ss_at_rise <= '1;
            rsp_sh     <= '0;
            rsp_rev    <= '0;
        end else begin
            if (sck !== prev_sck) begin
                if (prev_sck) begin
                    if (run < hi_min) hi_min <= run;
                    if (run > hi_max) hi_max <= run;
                end else if (rise_cnt > 0) begin
                    if (run < lo_min) lo_min <= run;
                    if (run > lo_max) lo_max <= run;
                end
                if (sck) begin
                    rise_cnt   <= rise_cnt + 1;
                    mosi_seq   <= {mosi_seq[14:0], mosi};
                    ss_at_rise <= ss_n;
                    if (rise_cnt < 8)  rsp_sh  <= {rsp_sh[6:0], mosi};
                    if (rise_cnt == 7) rsp_rev <= rev8({rsp_sh[6:0], mosi});
                end
                run <= 1;
            end else begin
                run <= run + 1;
            end
            if (sck && (mosi !== prev_mosi)) viol <= viol + 1;
        end
        prev_sck  <= sck;
        prev_mosi <= mosi;
    end

    always_comb begin
        miso = 1'b0;
        case (miso_mode)
            0: miso = mosi;
            1: miso = 1'b1;
            2: if (rise_cnt >= 8 && rise_cnt < 16) miso = rsp_rev[3'(15 - rise_cnt)];
            default: miso = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] data, input logic [3:0] len, input logic [7:0] ss);
        logic got;
        mon_clr = 1'b1;
        step();
        mon_clr   = 1'b0;
        req_data  = data;
        req_len   = len;
        req_ss    = ss;
        req_valid = 1'b1;
        got       = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req_ready) begin
                hs_cyc = cyc + 1;
                got    = 1'b1;
            end
            step();
        end
        req_valid = 1'b0;
        check("req_accept", 32'(got), 32'd1);
    endtask

    task automatic wait_resp(input int max, output int lat);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            if (resp_valid) found = 1'b1;
            else            step();
        end
        lat = found ? (cyc - hs_cyc) : -1;
        check("resp_seen", 32'(found), 32'd1);
    endtask

    task automatic check_shape(input string tag);
        check({tag, "_hi_min"}, 32'(hi_min), 32'd2);
        check({tag, "_hi_max"}, 32'(hi_max), 32'd2);
        check({tag, "_mode0"},  32'(viol),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic got;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_data   = '0;
        req_len    = '0;
        req_ss     = '0;
        resp_ready = 1'b1;
        miso_mode  = 0;
        mon_clr    = 1'b1;
        step();
        step();

        // Reset state
        check("rst_sck",        32'(sck),        32'd0);
        check("rst_ss_n",       32'(ss_n),       32'hFF);
        check("rst_mosi",       32'(mosi),       32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data",  32'(resp_data),  32'h0);
        resetn = 1'b1;
        step();
        check("rst_req_ready",  32'(req_ready),  32'd1);

        // 8-bit loopback, 0x5A on select 0
        miso_mode = 0;
        send(16'h005A, 4'd8, 8'h01);
        wait_resp(100, lat);
        check("lb8_data",     32'(resp_data),  32'h005A);
        check("lb8_latency",  32'(lat),        32'd34);
        check("lb8_edges",    32'(rise_cnt),   32'd8);
        check("lb8_mosi_seq", 32'(mosi_seq),   32'h005A);
        check("lb8_ss_n",     32'(ss_at_rise), 32'hFE);
        check("lb8_lo_min",   32'(lo_min),     32'd2);
        check("lb8_lo_max",   32'(lo_max),     32'd2);
        check_shape("lb8");
        check("lb8_done_ss_n", 32'(ss_n), 32'hFF);
        check("lb8_done_mosi", 32'(mosi), 32'd1);
        check("lb8_done_sck",  32'(sck),  32'd0);
        step();

        // 3-bit transfer with miso tied high
        miso_mode = 1;
        send(16'h0002, 4'd3, 8'h02);
        wait_resp(100, lat);
        check("ones3_data",     32'(resp_data), 32'h0007);
        check("ones3_latency",  32'(lat),       32'd14);
        check("ones3_edges",    32'(rise_cnt),  32'd3);
        check("ones3_mosi_seq", 32'(mosi_seq),  32'h0002);
        check("ones3_lo_max",   32'(lo_max),    32'd2);
        check_shape("ones3");
        step();

        // Full-length (len=0) loopback with response backpressure
        miso_mode  = 0;
        resp_ready = 1'b0;
        send(16'hA5C3, 4'd0, 8'h01);
        wait_resp(200, lat);
        check("full_data",     32'(resp_data), 32'hA5C3);
        check("full_latency",  32'(lat),       32'd66);
        check("full_edges",    32'(rise_cnt),  32'd16);
        check("full_mosi_seq", 32'(mosi_seq),  32'hA5C3);
        check_shape("full");
        req_data  = 16'h1234;
        req_len   = 4'd4;
        req_ss    = 8'h01;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_data",  32'(resp_data),  32'hA5C3);
            check("bp_req_ready",  32'(req_ready),  32'd0);
            check("bp_ss_n",       32'(ss_n),       32'hFF);
        end
        resp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        check("bp_after_valid", 32'(resp_valid), 32'd0);
        check("bp_after_ready", 32'(req_ready),  32'd1);
        step();
        check("bp_no_accept",   32'(req_ready),  32'd1);

        // Bit-reversal responder: 0xB1 in, reverse(0xB1)=0x8D back
        miso_mode = 2;
        send(16'hB100, 4'd0, 8'h01);
        wait_resp(200, lat);
        check("rsp_data",  32'(resp_data), 32'h008D);
        check("rsp_edges", 32'(rise_cnt),  32'd16);
        step();

        // Reset in the middle of a transfer
        miso_mode = 0;
        send(16'h003C, 4'd8, 8'h80);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (rise_cnt == 3) got = 1'b1;
            else               step();
        end
        check("mid_reached_3", 32'(got), 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_sck",        32'(sck),        32'd0);
        check("mid_ss_n",       32'(ss_n),       32'hFF);
        check("mid_mosi",       32'(mosi),       32'd1);
        check("mid_resp_valid", 32'(resp_valid), 32'd0);
        step();
        step();
        resetn = 1'b1;
        step();
        check("mid_req_ready", 32'(req_ready), 32'd1);
        send(16'h00C3, 4'd8, 8'h04);
        wait_resp(100, lat);
        check("post_data",    32'(resp_data),  32'h00C3);
        check("post_latency", 32'(lat),        32'd34);
        check("post_edges",   32'(rise_cnt),   32'd8);
        check("post_ss_n",    32'(ss_at_rise), 32'hFB);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-lane SPI mode-0 initiator.
- Drives sck, ss_n and mosi toward the SPI peripherals in the perip tree, such as the bit-reversal responder, and samples their miso.
- Core side uses a valid/ready request channel (tx data, length, slave select) and a valid/ready response channel (rx data).
- Transfers are full duplex, MSB first, 1..DATA_W bits, with sck derived from the system clock by a programmable divider.

Parameters:
DATA_W, 16, maximum bits per transfer (power of two, >=2); also the tx_data/rx_data width
SS_W, 8, number of slave-select lines
DIV, 2, system clock cycles per sck half-period (>=1)

Ports:
clock  input  1  system clock; all logic on posedge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when high together with req_valid
req_data  input  DATA_W  tx bits, right-aligned; the first bit sent is req_data[len-1]
req_len  input  $clog2(DATA_W)  bit count; 0 encodes DATA_W
req_ss  input  SS_W  slave select mask, bit i asserts ss_n[i]
resp_valid  output  1  rx result valid
resp_ready  input  1  result consumed when high together with resp_valid
resp_data  output  DATA_W  rx bits, right-aligned (last sampled bit in [0]), upper bits zero
sck  output  1  SPI clock, idle low
ss_n  output  SS_W  active-low selects
mosi  output  1  master out, idle high
miso  input  1  slave in

Behaviour:
- Clock and reset: one clock (`clock`); reset (`resetn`) is asynchronous and active-low.
- Reset state (asynchronous, takes effect immediately, including mid-transfer): state IDLE, sck=0, ss_n=all 1, mosi=1, resp_valid=0, resp_data=0, internal counters 0. req_ready=1 once resetn is high.
- States: IDLE, SETUP, HIGH, LOW, HOLD, DONE. A divider counter counts 0..DIV-1 in every non-IDLE/non-DONE state. A "half-period end" is the cycle where the counter equals DIV-1; the counter resets to 0 on every state change.
- IDLE:
  - req_ready=1 (req_ready is high only in IDLE).
  - On a handshake, latch len (0 mapped to DATA_W). Load the tx shift register left-aligned: req_data << (DATA_W-len). Clear the rx shift register.
  - Next state SETUP. In the same registered update: ss_n <= ~req_ss, mosi <= first bit.
- SETUP: sck=0 for DIV cycles. At half-period end: sck <= 1, go to HIGH.
- Rising sck edge (the transition into HIGH): on that same clock edge, sample miso into the rx shift register (shift left, miso into bit 0) and increment the bit counter.
- HIGH: at half-period end:
  - If bit counter == len: sck <= 0, go to HOLD.
  - Otherwise: sck <= 0, shift the tx register left so mosi <= next bit, go to LOW.
- LOW: at half-period end: sck <= 1, sample miso, go to HIGH.
- HOLD: sck=0, ss_n still asserted, mosi holds the last bit. At half-period end:
  - ss_n <= all 1, mosi <= 1.
  - resp_data <= rx register masked to len bits.
  - resp_valid <= 1, go to DONE.
- DONE: resp_valid and resp_data stay stable until resp_ready. On the handshake: resp_valid <= 0, go to IDLE. A new request can be accepted on the next cycle.
- Transfer shape:
  - Exactly len rising sck edges per transfer.
  - sck high and low phases are each exactly DIV clocks.
  - First resp_valid=1 cycle is DIV*(2*len+1) clocks after the request handshake edge.
- mosi changes only while sck is low (mode 0). The slave samples on rising edges; the master samples miso on the same rising edge.
- req_ss=0: the transfer still runs with no select asserted. Multiple set bits assert multiple selects.
- req_valid outside IDLE is ignored; the request must be held by the source until accepted.
- Counter widths: the divider counter holds DIV-1; the bit counter holds DATA_W without overflow.

Test Plan:
- Loopback (miso driven from mosi), DIV=2, req_len=8, req_data=0x005A, req_ss=0x01 -> 8 sck rising edges, mosi sequence 0,1,0,1,1,0,1,0, ss_n=0xFE during the transfer, resp_data=0x005A, resp_valid first high 34 clocks after the handshake.
- miso tied 1, req_len=3, req_data=0x0002 -> mosi 0,1,0, resp_data=0x0007, 3 sck pulses each high 2 and low 2 clocks.
- req_len=0, loopback, req_data=0xA5C3 -> 16 sck edges, resp_data=0xA5C3, latency 66 clocks.
- resp_ready held low 5 cycles after resp_valid -> resp_valid and resp_data stable, req_ready=0, a new req_valid is not accepted. After the resp handshake, req_ready=1 the next cycle.
- Bench 16-bit responder model (8 bits in, then 8 bits out on miso), req_len=0, req_data=0xB100 -> low byte of resp_data equals the responder's returned byte.
- resetn pulsed low mid-transfer (after 3 sck edges) -> the same cycle shows sck=0, ss_n=0xFF, mosi=1, resp_valid=0. After release, a fresh 8-bit loopback transfer completes correctly.
